vjtag_reg_bank: RTL and testbench

//  Generic DR engine behind the u_vjtag virtual JTAG instance.
//  - Decodes the virtual IR into N_CH parallel data channels plus a 1-bit bypass.
//  - Per channel: captures a parallel word, shifts it LSB-first over tdi/tdo, and presents the shifted-in word with a one-cycle valid strobe.
//  - Replaces per-design hand-coded 2-bit IR/DR logic; widths and channel count are parameters.

---
 rtl/vjtag_reg_bank.sv | 150 +++++++++++++++
 tb/tb_vjtag_reg_bank.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/vjtag_reg_bank.sv
// vjtag_reg_bank: virtual-JTAG DR engine, N_CH capture/shift/update channels plus 1-bit bypass.
// Optional shift-length checking enabled by VJTAG_LEN_CHECK_EN.  Rev 1.0
`default_nettype none

module vjtag_reg_bank #(
  parameter int IR_W = 2,
  parameter int DR_W = 32,
  parameter int N_CH = 3
) (
  input  logic                 tck,
  input  logic                 rst,
  input  logic                 tdi,
  output logic                 tdo,
  input  logic [IR_W-1:0]      ir_in,
  output logic [IR_W-1:0]      ir_out,
  input  logic                 virtual_state_cdr,
  input  logic                 virtual_state_sdr,
  input  logic                 virtual_state_e1dr,
  input  logic                 virtual_state_pdr,
  input  logic                 virtual_state_e2dr,
  input  logic                 virtual_state_udr,
  input  logic                 virtual_state_cir,
  input  logic                 virtual_state_uir,
  input  logic [N_CH*DR_W-1:0] cap_data,
  output logic [N_CH-1:0]      cap_ack,
  output logic [N_CH*DR_W-1:0] upd_data,
  output logic [N_CH-1:0]      upd_valid
);

  logic [IR_W-1:0]      ir_q, ir_d;
  logic [IR_W-1:0]      ir_out_q, ir_out_d;
  logic [DR_W-1:0]      sr_q, sr_d;
  logic                 byp_q, byp_d;
  logic [N_CH-1:0]      cap_ack_q, cap_ack_d;
  logic [N_CH*DR_W-1:0] upd_data_q, upd_data_d;
  logic [N_CH-1:0]      upd_valid_q, upd_valid_d;
  logic [N_CH-1:0]      ch_hit;
  logic                 sel;
  logic                 hold;
  logic                 shift_en;
  logic                 commit;

  // In a real TAP the hold states never overlap Shift-DR, so gating shift on them is free.
  assign hold     = virtual_state_e1dr | virtual_state_pdr | virtual_state_e2dr;
  assign shift_en = virtual_state_sdr & ~hold;

  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      ch_hit[c] = (ir_q == IR_W'(c + 1));
    end
  end
  assign sel = |ch_hit;

`ifdef VJTAG_LEN_CHECK_EN
  localparam int CNT_W = $clog2(DR_W + 2);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             len_err_q, len_err_d;

  assign commit = (cnt_q == CNT_W'(DR_W));

  always_comb begin
    cnt_d     = cnt_q;
    len_err_d = len_err_q;
    if (virtual_state_cdr) begin
      cnt_d = '0;
    end else if (shift_en) begin
      if (cnt_q != CNT_W'(DR_W + 1)) cnt_d = cnt_q + 1'b1;
    end else if (virtual_state_udr && sel && !commit) begin
      len_err_d = 1'b1;
    end
    if (virtual_state_uir) len_err_d = 1'b0;
  end

  always_ff @(posedge tck) begin
    if (rst) begin
      cnt_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      len_err_q <= len_err_d;
    end
  end
`else
  assign commit = 1'b1;
`endif

  always_comb begin
    ir_d        = virtual_state_uir ? ir_in : ir_q;
    ir_out_d    = ir_out_q;
    sr_d        = sr_q;
    byp_d       = byp_q;
    cap_ack_d   = '0;
    upd_data_d  = upd_data_q;
    upd_valid_d = '0;
    if (virtual_state_cir) begin
`ifdef VJTAG_LEN_CHECK_EN
      ir_out_d = {ir_q[IR_W-1:1], len_err_q};
`else
      ir_out_d = ir_q;
`endif
    end
    if (virtual_state_cdr) begin
      if (sel) begin
        for (int c = 0; c < N_CH; c++) begin
          if (ch_hit[c]) sr_d = cap_data[c*DR_W +: DR_W];
        end
        cap_ack_d = ch_hit;
      end else begin
        byp_d = 1'b0;
      end
    end else if (shift_en) begin
      if (sel) sr_d = {tdi, sr_q[DR_W-1:1]};
      else     byp_d = tdi;
    end else if (virtual_state_udr && sel && commit) begin
      for (int c = 0; c < N_CH; c++) begin
        if (ch_hit[c]) upd_data_d[c*DR_W +: DR_W] = sr_q;
      end
      upd_valid_d = ch_hit;
    end
  end

  always_ff @(posedge tck) begin
    if (rst) begin
      ir_q        <= '0;
      ir_out_q    <= '0;
      sr_q        <= '0;
      byp_q       <= 1'b0;
      cap_ack_q   <= '0;
      upd_data_q  <= '0;
      upd_valid_q <= '0;
    end else begin
      ir_q        <= ir_d;
      ir_out_q    <= ir_out_d;
      sr_q        <= sr_d;
      byp_q       <= byp_d;
      cap_ack_q   <= cap_ack_d;
      upd_data_q  <= upd_data_d;
      upd_valid_q <= upd_valid_d;
    end
  end

  assign tdo       = sel ? sr_q[0] : byp_q;
  assign ir_out    = ir_out_q;
  assign cap_ack   = cap_ack_q;
  assign upd_data  = upd_data_q;
  assign upd_valid = upd_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_vjtag_reg_bank.sv
// tb_vjtag_reg_bank: directed vector table plus multi-cycle sequences for vjtag_reg_bank.
`default_nettype none

module tb_vjtag_reg_bank;

  logic        tck = 1'b0;
  logic        rst, tdi, tdo;
  logic [1:0]  ir_in, ir_out;
  logic        cdr, sdr, e1dr, pdr, e2dr, udr, cir, uir;
  logic [95:0] cap_data, upd_data;
  logic [2:0]  cap_ack, upd_valid;

  int total = 0;
  int bad   = 0;
  int acks  = 0;

  always #5 tck = ~tck;

  vjtag_reg_bank #(.IR_W(2), .DR_W(32), .N_CH(3)) dut (
    .tck(tck), .rst(rst), .tdi(tdi), .tdo(tdo),
    .ir_in(ir_in), .ir_out(ir_out),
    .virtual_state_cdr(cdr), .virtual_state_sdr(sdr),
    .virtual_state_e1dr(e1dr), .virtual_state_pdr(pdr),
    .virtual_state_e2dr(e2dr), .virtual_state_udr(udr),
    .virtual_state_cir(cir), .virtual_state_uir(uir),
    .cap_data(cap_data), .cap_ack(cap_ack),
    .upd_data(upd_data), .upd_valid(upd_valid)
  );

  typedef struct {
    logic       uir, cdr, sdr, udr, tdi;
    logic [1:0] ir;
    logic       exp_tdo;
    logic [2:0] exp_ack, exp_valid;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(logic u, logic c, logic s, logic d, logic t, logic [1:0] ir,
                              logic et, logic [2:0] ea, logic [2:0] ev);
    vec_t v;
    v.uir = u; v.cdr = c; v.sdr = s; v.udr = d; v.tdi = t; v.ir = ir;
    v.exp_tdo = et; v.exp_ack = ea; v.exp_valid = ev;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    uir = 0; cir = 0; cdr = 0; sdr = 0; udr = 0; tdi = 0;
    e1dr = 0; pdr = 0; e2dr = 0; rst = 0;
  endtask

  task automatic tick();
    @(posedge tck);
    #1;
    acks += int'(cap_ack[0]);
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic select(input logic [1:0] code);
    idle(); uir = 1; ir_in = code; tick(); idle();
  endtask

  task automatic shift(input logic b);
    idle(); sdr = 1; tdi = b; #1; tick(); idle();
  endtask

  logic [31:0] din, dout, model;
  logic        tdo_hold;

  initial begin
    cap_data = {32'hDEAD_BEEF, 32'hCAFE_BABE, 32'hA5A5_0F0F};
    ir_in    = 2'd0;
    idle();

    // Reset state
    do_reset();
    chk("reset_tdo", 64'(tdo), 64'd0);
    chk("reset_ir_out", 64'(ir_out), 64'd0);
    chk("reset_upd_data", 64'(upd_data[63:0]), 64'd0);
    chk("reset_flags", 64'({cap_ack, upd_valid}), 64'd0);

    // Bypass tdo delay, then ch0 capture, and cdr+udr priority
    vecs[0]  = mk(1, 0, 0, 0, 0, 2'd0, 0, 3'b000, 3'b000);
    vecs[1]  = mk(0, 1, 0, 0, 0, 2'd0, 0, 3'b000, 3'b000);
    vecs[2]  = mk(0, 0, 1, 0, 1, 2'd0, 0, 3'b000, 3'b000);
    vecs[3]  = mk(0, 0, 1, 0, 0, 2'd0, 1, 3'b000, 3'b000);
    vecs[4]  = mk(0, 0, 1, 0, 1, 2'd0, 0, 3'b000, 3'b000);
    vecs[5]  = mk(0, 0, 0, 1, 0, 2'd0, 1, 3'b000, 3'b000);
    vecs[6]  = mk(1, 0, 0, 0, 0, 2'd1, 1, 3'b000, 3'b000);
    vecs[7]  = mk(0, 1, 0, 0, 0, 2'd1, 0, 3'b001, 3'b000);
    vecs[8]  = mk(0, 0, 0, 0, 0, 2'd1, 1, 3'b000, 3'b000);
    vecs[9]  = mk(0, 1, 0, 1, 0, 2'd1, 1, 3'b001, 3'b000);
    vecs[10] = mk(0, 0, 0, 0, 0, 2'd1, 1, 3'b000, 3'b000);
    for (int i = 0; i < 11; i++) begin
      idle();
      uir = vecs[i].uir; cdr = vecs[i].cdr; sdr = vecs[i].sdr;
      udr = vecs[i].udr; tdi = vecs[i].tdi; ir_in = vecs[i].ir;
      #1;
      chk($sformatf("vec%0d_tdo", i), 64'(tdo), 64'(vecs[i].exp_tdo));
      tick();
      chk($sformatf("vec%0d_ack", i), 64'(cap_ack), 64'(vecs[i].exp_ack));
      chk($sformatf("vec%0d_valid", i), 64'(upd_valid), 64'(vecs[i].exp_valid));
    end

    // Full 32-bit transfer on ch0
    do_reset();
    acks = 0;
    select(2'd1);
    idle(); cdr = 1; tick(); idle();
    din = 32'h1234_5678;
    for (int i = 0; i < 32; i++) begin
      idle(); sdr = 1; tdi = din[i]; #1;
      dout[i] = tdo;
      tick();
    end
    idle(); udr = 1; tick(); idle();
    chk("t1_tdo_stream", 64'(dout), 64'hA5A5_0F0F);
    chk("t1_upd_valid", 64'(upd_valid), 64'b001);
    chk("t1_upd_ch0", 64'(upd_data[31:0]), 64'h1234_5678);
    chk("t1_upd_ch12", 64'(upd_data[95:32]), 64'd0);
    tick();
    chk("t1_valid_pulse", 64'(upd_valid), 64'd0);
    chk("t1_ack_count", 64'(acks), 64'd1);

    // Paused shift on ch2
    select(2'd3);
    idle(); cdr = 1; tick(); idle();
    din = 32'h89AB_CDEF;
    for (int i = 0; i < 16; i++) shift(din[i]);
    tdo_hold = tdo;
    for (int i = 0; i < 5; i++) begin
      idle(); pdr = 1; tick();
    end
    idle(); #1;
    chk("t3_tdo_hold", 64'(tdo), 64'(tdo_hold));
    for (int i = 16; i < 32; i++) shift(din[i]);
    idle(); udr = 1; tick(); idle();
    chk("t3_upd_valid", 64'(upd_valid), 64'b100);
    chk("t3_upd_ch2", 64'(upd_data[95:64]), 64'h89AB_CDEF);
    chk("t3_upd_ch0_kept", 64'(upd_data[31:0]), 64'h1234_5678);

    // Reset mid-shift on ch1
    select(2'd2);
    idle(); cdr = 1; tick(); idle();
    for (int i = 0; i < 10; i++) shift(1'b1);
    idle(); rst = 1; tick(); idle();
    udr = 1; tick(); idle();
    chk("t4_upd_valid", 64'(upd_valid), 64'd0);
    chk("t4_upd_ch1", 64'(upd_data[63:32]), 64'd0);
    chk("t4_tdo", 64'(tdo), 64'd0);
    cir = 1; tick(); idle();
    chk("t4_ir_out", 64'(ir_out), 64'd0);

    // Short shift (31 bits) on ch1
    select(2'd2);
    idle(); cdr = 1; tick(); idle();
    din   = 32'h5A3C_96E1;
    model = 32'hCAFE_BABE;
    for (int i = 0; i < 31; i++) begin
      shift(din[i]);
      model = {din[i], model[31:1]};
    end
    idle(); udr = 1; tick(); idle();
`ifdef VJTAG_LEN_CHECK_EN
    chk("t5_upd_valid", 64'(upd_valid), 64'd0);
    chk("t5_upd_ch1", 64'(upd_data[63:32]), 64'd0);
    cir = 1; tick(); idle();
    chk("t5_ir_out", 64'(ir_out), 64'b11);
`else
    chk("t5_upd_valid", 64'(upd_valid), 64'b010);
    chk("t5_upd_ch1", 64'(upd_data[63:32]), 64'(model));
    cir = 1; tick(); idle();
    chk("t5_ir_out", 64'(ir_out), 64'b10);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
